// File: rtl/divu_unit_if.sv
// Handshake and result bundle between the issuing pipeline stage and the DIVU divider.
// Latency: pure wiring, none.
// Backpressure: none on the wires; the issuer must only start while the divider is not busy.
interface divu_unit_if #(
    parameter int WIDTH = 32
);
    logic               start;
    logic [WIDTH-1:0]   dataA;
    logic [WIDTH-1:0]   dataB;
    logic               busy;
    logic               done;
    logic               divByZero;
    logic [2*WIDTH-1:0] dataOut;

    // Issuer side: drives the request, observes status and result.
    modport master (
        output start, dataA, dataB,
        input  busy, done, divByZero, dataOut
    );

    // Divider side: consumes the request, drives status and result.
    modport slave (
        input  start, dataA, dataB,
        output busy, done, divByZero, dataOut
    );
endinterface

// File: rtl/divu_unit.sv
// Restoring shift-subtract unsigned divider producing {remainder, quotient} for HI/LO.
// Latency: WIDTH+1 edges from accepted start to the done pulse; one quotient bit per clock.
// Backpressure: start is ignored while busy; a start during the done cycle is accepted back-to-back.
module divu_unit #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    divu_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              nextState;

    logic [WIDTH-1:0]    divReg;
    logic [2*WIDTH-1:0]  work;
    logic [CW-1:0]       cnt;
    logic                divByZero;
    logic [2*WIDTH-1:0]  dataOut;

    logic                accept;
    logic                lastIter;
    logic [2*WIDTH-1:0]  shifted;
    logic [WIDTH:0]      trial;
    logic                trialFits;
    logic [WIDTH-1:0]    diffLow;
    logic [2*WIDTH-1:0]  stepWork;

    // Request acceptance and loop termination decode.
    always_comb begin
        accept   = bus.start && (state != RUN);
        lastIter = (cnt == CW'(WIDTH - 1));
    end

    // One restoring step: shift left, trial-subtract the divisor from the upper half.
    // The bit shifted out of the top is kept as the 33rd bit of the trial value,
    // otherwise divisors above 2^31 would lose the carry and give a wrong quotient.
    always_comb begin
        shifted   = {work[2*WIDTH-2:0], 1'b0};
        trial     = {work[2*WIDTH-1], shifted[2*WIDTH-1:WIDTH]};
        trialFits = (trial >= {1'b0, divReg});
        diffLow   = trial[WIDTH-1:0] - divReg;
        stepWork  = shifted;
        if (trialFits) begin
            stepWork[2*WIDTH-1:WIDTH] = diffLow;
            stepWork[0]               = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode; DONE re-enters RUN directly when a new request is waiting.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                if (lastIter) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                nextState = bus.start ? RUN : IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Operand capture, iteration datapath and result publication.
    // dataOut is only written on the edge entering DONE so the partial word never leaks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            divReg    <= '0;
            work      <= '0;
            cnt       <= '0;
            divByZero <= 1'b0;
            dataOut   <= '0;
        end else if (accept) begin
            divReg    <= bus.dataB;
            work      <= {{WIDTH{1'b0}}, bus.dataA};
            cnt       <= '0;
            divByZero <= (bus.dataB == '0);
        end else if (state == RUN) begin
            work <= stepWork;
            cnt  <= cnt + CW'(1);
            if (lastIter) begin
                dataOut <= stepWork;
            end
        end
    end

    // Status flags decode straight from the state flop; the others come from registers.
    assign bus.busy      = (state == RUN);
    assign bus.done      = (state == DONE);
    assign bus.divByZero = divByZero;
    assign bus.dataOut   = dataOut;

endmodule

// File: doc/divu_unit.md
# divu_unit

Sequential 32-bit unsigned divider for the DIVU instruction (funct 6'b011011). It sits beside the multiplier, directly upstream of the HI/LO register pair. It takes the two ALU operands on a single-cycle start strobe and runs a restoring shift-subtract loop, one quotient bit per clock. It then presents a 64-bit {remainder, quotient} word that HI/LO captures on the done pulse.

## Interface
- WIDTH, 32, operand width; dataOut is 2*WIDTH; the iteration count equals WIDTH.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; operands are sampled on the same edge.
- dataA  input  WIDTH  dividend, unsigned.
- dataB  input  WIDTH  divisor, unsigned.
- busy  output  1  high while an operation is running.
- done  output  1  one-cycle pulse; dataOut is valid and new.
- divByZero  output  1  dataB was 0 for the operation that produced the current dataOut.
- dataOut  output  2*WIDTH  {remainder[63:32] -> HI, quotient[31:0] -> LO}.

## Operation
- FSM states:
  - IDLE: waiting for start.
  - RUN: iterating.
  - DONE: result just published.
- IDLE + start -> RUN:
  - latch the divisor into divReg.
  - load the 64-bit working register with {32'b0, dataA}.
  - clear the counter cnt.
  - set divByZero to (dataB == 0).
- RUN, each cycle:
  - shift the working register left by 1.
  - compute the trial difference: upper half − divReg, using a 33-bit subtract.
  - if the difference is non-negative, the upper half takes the difference and bit 0 becomes 1.
  - otherwise bit 0 stays 0.
  - increment cnt.
- RUN exit: when cnt reaches WIDTH−1 and that iteration completes, register the final word into dataOut and go to DONE.
- DONE: done = 1.
  - If start is high in DONE, it is accepted exactly as in IDLE and the next state is RUN (back-to-back issue).
  - Otherwise the next state is IDLE.
- start while in RUN is ignored. Operands are not re-sampled and no error is raised.
- Divide by zero uses the same algorithm and the same latency, with no special path:
  - quotient = 32'hFFFFFFFF.
  - remainder = dividend.
  - divByZero = 1.
- dataOut changes only on the edge that enters DONE; it holds its value in IDLE and RUN. The partial working register is never visible.
- divByZero holds its value until the next accepted start.
- Result invariant for dataB ≠ 0: quotient*dataB + remainder == dataA, and remainder < dataB.

## Timing
- Reset (reset = 0, takes effect at once, no clock needed):
  - state = IDLE.
  - busy = 0, done = 0, divByZero = 0.
  - dataOut = 0, cnt = 0.
- Reset mid-RUN aborts the operation. After release the block is in IDLE and dataOut = 0.
- Start accepted at edge N:
  - busy = 1 after edge N, through edge N+32.
  - RUN iterations happen on edges N+1 … N+32.
  - DONE is entered at edge N+32; done = 1 and dataOut valid for the cycle following edge N+32.
  - At edge N+33, done = 0; the block is in IDLE, or back in RUN if start was high.
- Latency: start edge to done assertion = WIDTH + 1 edges (33).
- Maximum throughput is one operation per 33 cycles, using back-to-back start in DONE.
- busy and done are never both 1.
- HI/LO captures dataOut on the edge that ends the done cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- 100 / 7:
  - start at edge N -> done at cycle N+32.
  - dataOut = 64'h00000002_0000000E.
  - divByZero = 0.
  - busy high for exactly 32 cycles.
- 32'hFFFFFFFF / 32'h00000001 -> dataOut = 64'h00000000_FFFFFFFF.
- 32'h00000005 / 32'hFFFFFFFF -> dataOut = 64'h00000005_00000000.
- 32'h00001234 / 0:
  - dataOut = 64'h00001234_FFFFFFFF.
  - divByZero = 1.
  - same 33-edge latency.
  - divByZero clears on the next start with a non-zero divisor.
- 50 / 5, with start re-asserted with 9/2 at cycle N+10:
  - the second start is ignored.
  - result = 64'h00000000_0000000A.
  - then 9/2 issued in the DONE cycle -> runs back-to-back; next done 33 cycles later with 64'h00000001_00000004.
- Start 1000/3, then pull reset low at cycle N+15 for 2 cycles:
  - busy and done drop immediately; dataOut = 0.
  - no done pulse occurs.
  - a fresh 7/7 afterwards returns 64'h00000000_00000001.
- Randomized: 1000 operand pairs checked against the quotient/remainder invariant above.
